// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: per-channel synchroniser plus a 4-state stability FSM.
// Optional auto-repeat of the press pulse is enabled by defining MULTI_DEBOUNCER_REPEAT_EN.
module multi_debouncer #(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned STABLE_CYCLES = 20_000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {StLow, StArmHi, StHigh, StArmLo} state_e;

    if (STABLE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
    begin : g_param_check
        $error("multi_debouncer: illegal parameter value");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_e                 state_q, state_d;
        logic [CntW-1:0]        cnt_q, cnt_d;
        logic                   db_q, db_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   rep_pulse;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            db_d    = db_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                StLow: begin
                    db_d = 1'b0;
                    if (s) begin
                        state_d = StArmHi;
                        cnt_d   = '0;
                    end
                end
                StArmHi: begin
                    db_d = 1'b0;
                    if (!s) begin
                        state_d = StLow;
                    end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
                        state_d = StHigh;
                        db_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StHigh: begin
                    db_d = 1'b1;
                    if (!s) begin
                        state_d = StArmLo;
                        cnt_d   = '0;
                    end
                end
                StArmLo: begin
                    db_d = 1'b1;
                    if (s) begin
                        state_d = StHigh;
                    end else if (cnt_q == CntW'(STABLE_CYCLES - 1)) begin
                        state_d = StLow;
                        db_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StLow;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                end
            endcase
        end

`ifdef MULTI_DEBOUNCER_REPEAT_EN
        localparam int unsigned RepMax =
            (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned RcntW = $clog2(RepMax + 1);

        logic [RcntW-1:0] rcnt_q, rcnt_d;
        logic             rep_q, rep_d;

        // rep_q marks that the initial delay has elapsed and the period now applies.
        always_comb begin
            rcnt_d    = '0;
            rep_d     = 1'b0;
            rep_pulse = 1'b0;
            if (state_q == StHigh && s) begin
                rep_d = rep_q;
                if (!rep_q && rcnt_q == RcntW'(REPEAT_DELAY - 1)) begin
                    rep_pulse = 1'b1;
                    rep_d     = 1'b1;
                end else if (rep_q && rcnt_q == RcntW'(REPEAT_PERIOD - 1)) begin
                    rep_pulse = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt_q <= '0;
                rep_q  <= 1'b0;
            end else begin
                rcnt_q <= rcnt_d;
                rep_q  <= rep_d;
            end
        end
`else
        assign rep_pulse = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StLow;
                cnt_q   <= '0;
                db_q    <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                db_q    <= db_d;
                rise_q  <= rise_d | rep_pulse;
                fall_q  <= fall_d;
            end
        end

        assign db[i]   = db_q;
        assign rise[i] = rise_q;
        assign fall[i] = fall_q;
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed self-checking bench for multi_debouncer with small timing parameters.
// Expectations follow MULTI_DEBOUNCER_REPEAT_EN when it is defined for the build.
module tb_multi_debouncer;

    localparam int unsigned N_CH = 3;

    logic            clk;
    logic            rst_n;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] db;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    multi_debouncer #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(4),
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .db   (db),
        .rise (rise),
        .fall (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int n_rise;
    int n_fall;
    logic rep_exp;

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        #12;
        check("reset_db", 32'(db), 32'd0);
        check("reset_rise", 32'(rise), 32'd0);
        check("reset_fall", 32'(fall), 32'd0);
        rst_n = 1'b1;
        ticks(3);

        // Clean press on channel 0: pulse after edge 6.
        btn = 3'b001;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("press_rise0", 32'(rise[0]), 32'(j == 7));
            check("press_db0", 32'(db[0]), 32'(j >= 7));
            check("press_db12", 32'(db[2:1]), 32'd0);
        end

        // Bounce on channel 1, then settle high.
        n_rise = 0;
        n_fall = 0;
        for (int b = 0; b < 4; b++) begin
            btn[1] = (b % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick();
                n_rise += int'(rise[1]);
                n_fall += int'(fall[1]);
            end
        end
        btn[1] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check("bounce_rise1_time", 32'(rise[1]), 32'(j == 7));
            n_rise += int'(rise[1]);
            n_fall += int'(fall[1]);
        end
        check("bounce_rise1_count", 32'(n_rise), 32'd1);
        check("bounce_fall1_count", 32'(n_fall), 32'd0);
        check("bounce_db1", 32'(db[1]), 32'd1);

        // One-cycle low glitch on channel 0 is rejected.
        btn[0] = 1'b0;
        tick();
        btn[0] = 1'b1;
        n_fall = 0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            n_fall += int'(fall[0]);
            check("glitch_db0", 32'(db[0]), 32'd1);
        end
        check("glitch_fall0_count", 32'(n_fall), 32'd0);

        // Real release on channel 0.
        btn[0] = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("release_fall0", 32'(fall[0]), 32'(j == 7));
            check("release_db0", 32'(db[0]), 32'(j < 7));
            check("release_excl0", 32'(rise[0] & fall[0]), 32'd0);
        end

        // Simultaneous press on channels 0 and 2.
        btn = 3'b111;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("simul_rise0", 32'(rise[0]), 32'(j == 7));
            check("simul_rise2", 32'(rise[2]), 32'(j == 7));
        end

        // Async reset while channel 0 is arming (cnt=2) and channel 1 is high.
        btn = 3'b010;
        ticks(10);
        check("pre_arm_db", 32'(db), 32'b010);
        btn = 3'b011;
        ticks(5);
        check("arming_db", 32'(db), 32'b010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_db", 32'(db), 32'd0);
        check("async_rst_rise", 32'(rise), 32'd0);
        check("async_rst_fall", 32'(fall), 32'd0);
        #2 rst_n = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("post_rst_rise", 32'(rise), (j == 7) ? 32'b011 : 32'd0);
            check("post_rst_fall", 32'(fall), 32'd0);
        end

        // Long hold on channel 0: auto-repeat when enabled, single pulse otherwise.
        btn = 3'b000;
        ticks(12);
        check("idle_db", 32'(db), 32'd0);
        btn = 3'b001;
        for (int j = 1; j <= 33; j++) begin
            tick();
`ifdef MULTI_DEBOUNCER_REPEAT_EN
            rep_exp = (j - 1 == 6) || (j - 1 == 16) || (j - 1 == 19) || (j - 1 == 22) ||
                      (j - 1 == 25) || (j - 1 == 28) || (j - 1 == 31);
`else
            rep_exp = (j - 1 == 6);
`endif
            check("hold_rise0", 32'(rise[0]), 32'(rep_exp));
        end
        check("hold_db0", 32'(db[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
